led_blinker_mc: RTL

- Multi-channel LED driver; parametrised successor to the single-counter LED blinker.
- Each of NCH channels is independently configured to OFF, ON, BLINK (programmable half-period) or PWM (programmable duty, prescaled).
- Sits between a simple config master (bring-up FSM or CSR bridge) and board LED pins.
- Replaces fixed counter-bit LED taps in top-levels.

---
 rtl/led_blinker_mc.sv | 136 +++++++++++++
 1 files changed

// File: rtl/led_blinker_mc.sv
// Multi-channel LED driver: per-channel OFF / ON / BLINK / PWM with registered outputs.
// Optional `LED_SYNC_EN adds a SYNC input that phase-aligns all BLINK/PWM channels.
module led_blinker_mc #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PWM_W = 8,
  parameter int unsigned CHW   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CFG_WE,
  input  logic [CHW-1:0]   CFG_CH,
  input  logic [1:0]       CFG_MODE,
  input  logic [WIDTH-1:0] CFG_PERIOD,
  input  logic [PWM_W-1:0] CFG_DUTY,
  output logic             CFG_ACK,
  output logic             CFG_ERR,
  output logic [NCH-1:0]   ULED
`ifdef LED_SYNC_EN
  ,
  input  logic             SYNC
`endif
);

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModePwm   = 2'd3
  } mode_e;

  mode_e            mode_q   [NCH];
  mode_e            mode_d   [NCH];
  logic [WIDTH-1:0] period_q [NCH];
  logic [WIDTH-1:0] period_d [NCH];
  logic [PWM_W-1:0] duty_q   [NCH];
  logic [PWM_W-1:0] duty_d   [NCH];
  logic [WIDTH-1:0] sub_q    [NCH];
  logic [WIDTH-1:0] sub_d    [NCH];
  logic [PWM_W-1:0] pwm_q    [NCH];
  logic [PWM_W-1:0] pwm_d    [NCH];
  logic [NCH-1:0]   led_q, led_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             wr_valid;
  logic             sync;

`ifdef LED_SYNC_EN
  assign sync = SYNC;
`else
  assign sync = 1'b0;
`endif

  assign wr_valid = 32'(CFG_CH) < NCH;

  always_comb begin
    led_d = led_q;
    ack_d = CFG_WE & wr_valid;
    err_d = CFG_WE & ~wr_valid;
    for (int unsigned i = 0; i < NCH; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      sub_d[i]    = sub_q[i];
      pwm_d[i]    = pwm_q[i];
      unique case (mode_q[i])
        ModeOff: led_d[i] = 1'b0;
        ModeOn:  led_d[i] = 1'b1;
        ModeBlink: begin
          if (sub_q[i] == period_q[i]) begin
            sub_d[i] = '0;
            led_d[i] = ~led_q[i];
          end else begin
            sub_d[i] = sub_q[i] + WIDTH'(1);
          end
        end
        ModePwm: begin
          if (sub_q[i] == period_q[i]) begin
            sub_d[i] = '0;
            pwm_d[i] = pwm_q[i] + PWM_W'(1);
          end else begin
            sub_d[i] = sub_q[i] + WIDTH'(1);
          end
          // Compare uses the pre-edge phase, giving a one-cycle lag.
          led_d[i] = pwm_q[i] < duty_q[i];
        end
        default: led_d[i] = 1'b0;
      endcase
      if (sync) begin
        sub_d[i] = '0;
        pwm_d[i] = '0;
        if (mode_q[i] == ModeBlink || mode_q[i] == ModePwm) led_d[i] = 1'b0;
      end
      // A write restarts the channel from zero phase, overriding everything above.
      if (CFG_WE && wr_valid && (32'(CFG_CH) == i)) begin
        mode_d[i]   = mode_e'(CFG_MODE);
        period_d[i] = CFG_PERIOD;
        duty_d[i]   = CFG_DUTY;
        sub_d[i]    = '0;
        pwm_d[i]    = '0;
        led_d[i]    = (mode_e'(CFG_MODE) == ModeOn);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        mode_q[i]   <= ModeOff;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        sub_q[i]    <= '0;
        pwm_q[i]    <= '0;
      end
      led_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        sub_q[i]    <= sub_d[i];
        pwm_q[i]    <= pwm_d[i];
      end
      led_q <= led_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign ULED    = led_q;
  assign CFG_ACK = ack_q;
  assign CFG_ERR = err_q;

endmodule
